// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART word controllers (transmit and receive),
// so both sides agree on byte order, state encoding and timeout default.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    DONE      = 2'd2
  } rx_state_t;

  // Words are sent low byte first, two bytes per word.
  localparam int BYTES_PER_WORD = 2;

  // 1 ms at 100 MHz.
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte timeout counter: cleared when a low byte is taken, counts while
// the high byte is awaited, flags expiry on reaching TIMEOUT_CYCLES-1.
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority over count so a fresh low byte always restarts the window.
  always_ff @(posedge clk) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rx_word_assembler.sv
// Pairs received bytes (low first) into 16-bit words with a one-cycle valid
// pulse; a pending low byte is dropped if the high byte does not follow in time.
module rx_word_assembler
  import uart_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic [15:0] word_data,
  output logic        word_valid,
  output logic        timeout_err,
  output logic        busy,
  output logic [7:0]  word_count,
  output logic [1:0]  state_id
);

  rx_state_t  state, state_nxt;
  logic [7:0] low_reg;
  logic       low_load, word_load, tmo, cnt_clr, cnt_en, expired;

  rx_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  // Next-state and datapath controls; an arriving byte beats a same-cycle expiry.
  always_comb begin
    state_nxt = state;
    low_load  = 1'b0;
    word_load = 1'b0;
    tmo       = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_ready) begin
          low_load  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_ready) begin
          word_load = 1'b1;
          state_nxt = DONE;
        end else if (expired) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_en    = 1'b1;
        end
      end
      DONE: begin
        // A byte landing in the valid cycle starts the next word.
        if (rx_ready) begin
          low_load  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = WAIT_HIGH;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, held low byte, assembled word, word counter and registered timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      low_reg     <= 8'h00;
      word_data   <= 16'h0000;
      word_count  <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= tmo;
      if (low_load)  low_reg <= rx_data;
      else if (tmo)  low_reg <= 8'h00;
      if (word_load) begin
        word_data  <= {rx_data, low_reg};
        word_count <= word_count + 8'd1;
      end
    end
  end

  assign word_valid = (state == DONE);
  assign busy       = (state == WAIT_HIGH);
  assign state_id   = state;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Randomized scoreboard bench for rx_word_assembler. The reference model
// tracks a pending low byte and its age in clock edges; words and timeout
// pulses are queued with the cycle they must appear in.
module tb_rx_word_assembler;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset, rx_ready;
  logic [7:0]  rx_data;
  logic [15:0] word_data;
  logic        word_valid, timeout_err, busy;
  logic [7:0]  word_count;
  logic [1:0]  state_id;

  rx_word_assembler #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .word_data(word_data), .word_valid(word_valid), .timeout_err(timeout_err),
    .busy(busy), .word_count(word_count), .state_id(state_id)
  );

  always #5 clk = ~clk;

  typedef struct { logic busy; logic [1:0] st; logic [15:0] wd; logic [7:0] wc; } cyc_t;
  typedef struct { int tag; logic [15:0] d; logic [7:0] c; } word_t;

  cyc_t  cq[$];
  word_t wq[$];
  int    tq[$];

  int checks = 0, passed = 0;

  // Model state
  bit          m_pend = 0;
  logic [7:0]  m_low  = 0;
  logic [7:0]  m_cnt  = 0;
  logic [15:0] m_wd   = 0;
  int          m_age  = 0;
  int          m_edge = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    else passed++;
  endtask

  // One clock of stimulus; the model predicts the effect of the coming edge.
  task automatic step(input bit rst, input bit rdy, input logic [7:0] d);
    logic [1:0] st;
    @(negedge clk);
    reset    = rst;
    rx_ready = rdy;
    rx_data  = rdy ? d : 8'($urandom);
    m_edge++;
    st = 2'd0;
    if (rst) begin
      m_pend = 0; m_cnt = 0; m_wd = 0; m_low = 0;
    end else if (m_pend) begin
      m_age++;
      if (rdy) begin
        m_wd  = {d, m_low};
        m_cnt = m_cnt + 8'd1;
        wq.push_back('{m_edge, m_wd, m_cnt});
        m_pend = 0;
        st = 2'd2;
      end else if (m_age == T) begin
        tq.push_back(m_edge);
        m_pend = 0;
      end
    end else if (rdy) begin
      m_pend = 1; m_low = d; m_age = 0;
    end
    if (m_pend) st = 2'd1;
    cq.push_back('{m_pend, st, m_wd, m_cnt});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  // Monitor: compares every modelled cycle, popping word/timeout expectations
  // when their cycle comes up.
  initial begin : monitor
    int   mcyc;
    cyc_t r;
    word_t w;
    bit   ev;
    mcyc = 0;
    forever begin
      @(posedge clk); #1;
      if (cq.size() > 0) begin
        r = cq.pop_front();
        mcyc++;
        chk("busy", 32'(busy), 32'(r.busy));
        chk("state_id", 32'(state_id), 32'(r.st));
        chk("word_data", 32'(word_data), 32'(r.wd));
        chk("word_count", 32'(word_count), 32'(r.wc));
        ev = (wq.size() > 0) && (wq[0].tag == mcyc);
        chk("word_valid", 32'(word_valid), 32'(ev));
        if (ev) begin
          w = wq.pop_front();
          chk("word_value", 32'(word_data), 32'(w.d));
          chk("word_count_at_valid", 32'(word_count), 32'(w.c));
        end
        ev = (tq.size() > 0) && (tq[0] == mcyc);
        chk("timeout_err", 32'(timeout_err), 32'(ev));
        if (ev) void'(tq.pop_front());
      end
    end
  end

  initial begin
    int p;
    reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
    // reset state
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);

    // pair 34 then 12, six edges apart
    step(0, 1, 8'h34); idle(5); step(0, 1, 8'h12); idle(3);

    // timeout on lone byte, then a clean pair
    step(0, 1, 8'hAA); idle(12);
    step(0, 1, 8'h01); step(0, 1, 8'h02); idle(2);

    // boundary: high byte on the last allowed cycle
    step(0, 1, 8'hC1); idle(T - 1); step(0, 1, 8'hC2); idle(2);
    // one cycle later: timeout, late byte becomes new low
    step(0, 1, 8'hD1); idle(T); step(0, 1, 8'hD2); idle(1); step(0, 1, 8'hD3); idle(2);

    // back-to-back, third byte lands in the valid cycle
    step(0, 1, 8'h11); step(0, 1, 8'h22); step(0, 1, 8'h33); step(0, 1, 8'h44); idle(2);

    // reset mid-word
    step(1, 0, 0);
    step(0, 1, 8'h55); idle(2); step(1, 0, 0);
    step(0, 1, 8'h66); step(0, 1, 8'h77); idle(2);

    // randomized traffic with varying strobe density and rare resets
    for (int b = 0; b < 5; b++) begin
      case (b)
        0: p = 50; 1: p = 15; 2: p = 90; 3: p = 5; default: p = 30;
      endcase
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < p, 8'($urandom));
    end

    // wrap: 256 words from reset, counter must return to 0
    step(1, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 8'(i));
      step(0, 1, 8'(~i));
    end
    idle(T + 4);

    @(posedge clk); #2;
    chk("words_left", 32'(wq.size()), 32'd0);
    chk("timeouts_left", 32'(tq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rx_word_assembler.md
Name: rx_word_assembler

Overview:
- Receive-side counterpart of the two-byte UART transmit controller.
- Sits behind the UART receiver and takes its byte strobe (rx_ready) and byte (rx_data).
- Reassembles two consecutive bytes, low byte first, into one 16-bit word and presents it with a one-cycle valid pulse.
- Guards the high byte with an inter-byte timeout so a lost byte cannot permanently misalign the byte pairing.

Parameters:
- TIMEOUT_CYCLES, 100000: clk cycles allowed between the low byte and the high byte (1 ms at 100 MHz); legal range is 2 or more.
- CNT_W, 17: width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- rx_ready  input  1  one-cycle strobe from the UART receiver: rx_data holds a valid byte this cycle
- rx_data  input  8  received byte, sampled only when rx_ready=1
- word_data  output  16  last assembled word {high, low}; held stable until the next word completes
- word_valid  output  1  one-cycle pulse in the DONE state; word_data is valid in that same cycle
- timeout_err  output  1  one-cycle pulse when a pending low byte is discarded on timeout
- busy  output  1  high while a low byte is held (WAIT_HIGH)
- word_count  output  8  number of completed words, wraps 255->0
- state_id  output  2  current state encoding, for debug/LEDs

Behaviour:
- Reset values:
  - state=IDLE
  - word_data=16'h0000
  - word_valid=0, timeout_err=0, busy=0
  - word_count=0
  - internal low-byte register=0, timeout counter=0
- Reset acts on the next clk edge, even mid-word: any held low byte is dropped and no pulse is produced.
- States: IDLE=0, WAIT_HIGH=1, DONE=2. Encoding 3 is unused and recovers to IDLE.
- IDLE:
  - On rx_ready: low_reg<=rx_data, counter<=0, go to WAIT_HIGH.
  - Otherwise stay.
- WAIT_HIGH:
  - busy=1.
  - On rx_ready: word_data<={rx_data, low_reg}, word_count<=word_count+1, go to DONE.
  - Else if counter==TIMEOUT_CYCLES-1: go to IDLE, timeout_err=1 for one cycle, low_reg discarded.
  - Otherwise counter<=counter+1.
- Simultaneous rx_ready and timeout expiry in WAIT_HIGH: the byte wins. The word completes and no timeout_err is raised.
- DONE:
  - word_valid=1 for exactly this one cycle. Latency is one clk from the high-byte rx_ready to word_valid.
  - If rx_ready also arrives in DONE, that byte is the low byte of the next word: low_reg<=rx_data, counter<=0, go to WAIT_HIGH.
  - Otherwise go to IDLE.
- Output timing:
  - word_valid and busy decode combinationally from state.
  - timeout_err is registered: it goes high the cycle after the expiry decision, while the state is IDLE.
- word_data is never changed by a timeout, by an incomplete word, or by the arrival of a low byte.
- rx_data is ignored whenever rx_ready=0.

Decomposition:
- Shared package uart_ctrl_pkg holds:
  - the state enum type (IDLE, WAIT_HIGH, DONE) with 2-bit encoding;
  - the constant BYTES_PER_WORD=2;
  - the default TIMEOUT_CYCLES constant;

  so that transmit and receive controllers agree on byte order and encoding.
- One natural sub-module: rx_timeout_counter. It is a loadable up-counter with clear, enable and an expired output compared against TIMEOUT_CYCLES-1.
- The FSM and datapath stay in rx_word_assembler.

Test Plan:
- Pair: rx_ready with 8'h34, then 10 cycles later rx_ready with 8'h12 -> word_data=16'h1234 and word_valid high for one cycle, one clk after the second strobe; word_count=1; timeout_err never asserts.
- Timeout (TIMEOUT_CYCLES=8): single byte 8'hAA, then no strobes -> timeout_err pulses once, the state is IDLE, and word_data is unchanged. A following pair 8'h01, 8'h02 then gives 16'h0201.
- Boundary (TIMEOUT_CYCLES=8): second byte arriving exactly on the cycle where counter==7 -> word completes, no timeout_err. The same stimulus one cycle later -> timeout_err, and the late byte is taken as a new low byte (busy=1).
- Back-to-back: bytes 8'h11, 8'h22, 8'h33, 8'h44 with the third strobe landing in the DONE cycle -> two word_valid pulses, with values 16'h2211 then 16'h4433; word_count=2.
- Reset mid-operation: low byte 8'h55, then reset asserted for 1 cycle, then the pair 8'h66, 8'h77 -> no word containing 8'h55; output is 16'h7766; word_count=1.
- Wrap: 256 complete words -> word_count returns to 0 after the 256th word_valid.
